// File: rtl/fpga_cfg_pkg.sv
// rtl/fpga_cfg_pkg.sv - shared types and CRC-8 helper for the config chain loader
// Contents: loader state enum, CRC-8 constants (poly 0x07, init 0x00), one-bit CRC step.
package fpga_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VERIFY,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } cfg_state_t;

    localparam logic [7:0] CFG_CRC_POLY = 8'h07;
    localparam logic [7:0] CFG_CRC_INIT = 8'h00;

    // One serial step, MSB-first, no reflection, no final XOR.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? CFG_CRC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ccff_cfg_loader_if.sv
// rtl/ccff_cfg_loader_if.sv - bitstream word stream between host port and loader
// Signals: s_data (word, MSB first), s_valid (word valid), s_ready (loader accepts).
// Modports: master drives data/valid, slave returns ready.
interface ccff_cfg_loader_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ccff_crc8.sv
// rtl/ccff_crc8.sv - serial bit-in CRC-8 accumulator with clear and enable
// Ports: clk, rst (sync, active-high), clr (load init value), en (absorb bit_in), bit_in, crc (state).
module ccff_crc8
    import fpga_cfg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= CFG_CRC_INIT;
        end else if (en) begin
            crc <= crc8_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/ccff_cfg_loader.sv
// rtl/ccff_cfg_loader.sv - loads, recirculates and CRC-verifies the IO tile config chain
// Ports: prog_clk, prog_reset (sync, active-high), start, cfg (slave word stream),
//        ccff_head/ccff_tail (chain ends), ccff_shift_en (chain clock enable),
//        IO_ISOL_N (0 = isolated), busy, done, error (status levels).
module ccff_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 88,
    parameter int DATA_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    ccff_cfg_loader_if.slave  cfg,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic              IO_ISOL_N,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int KW = $clog2(DATA_W + 1);

    cfg_state_t        state, st_n;
    logic [DATA_W-1:0] sreg, sreg_n;
    logic [KW-1:0]     cnt, cnt_n;     // bits of sreg still to shift out
    logic [CW-1:0]     acc, acc_n;     // bits accepted into the chain so far
    logic [CW-1:0]     vcnt, vcnt_n;   // recirculation cycles done
    logic              head_q, shift_en_q, isol_q, busy_q, done_q, error_q;
    logic              crc_clr, load_shift, ready, accept;
    logic [7:0]        crc_load, crc_ver;
    int                rem_bits, take_bits;

    assign load_shift = (state == ST_LOAD) && (cnt != '0);

    // A word may land in the same cycle the last bit of the previous one
    // leaves, so consecutive words shift without a bubble.
    assign ready  = (state == ST_LOAD) && (acc != CW'(CHAIN_LEN)) && (cnt <= KW'(1));
    assign accept = ready && cfg.s_valid;

    // The final word only contributes what the chain still needs; its
    // low-order surplus bits sit in sreg and are never shifted.
    always_comb begin
        rem_bits  = CHAIN_LEN - int'(acc);
        take_bits = (rem_bits < DATA_W) ? rem_bits : DATA_W;
    end

    always_comb begin
        st_n    = state;
        sreg_n  = sreg;
        cnt_n   = cnt;
        acc_n   = acc;
        vcnt_n  = vcnt;
        crc_clr = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    st_n    = ST_LOAD;
                    sreg_n  = '0;
                    cnt_n   = '0;
                    acc_n   = '0;
                    vcnt_n  = '0;
                    crc_clr = 1'b1;
                end
            end
            ST_LOAD: begin
                if (load_shift) begin
                    sreg_n = sreg << 1;
                    cnt_n  = cnt - KW'(1);
                end
                if (accept) begin
                    sreg_n = cfg.s_data;
                    cnt_n  = KW'(take_bits);
                    acc_n  = acc + CW'(take_bits);
                end else if (load_shift && (cnt == KW'(1)) && (acc == CW'(CHAIN_LEN))) begin
                    st_n = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                vcnt_n = vcnt + CW'(1);
                if (vcnt == CW'(CHAIN_LEN - 1)) begin
                    st_n = ST_CHECK;
                end
            end
            ST_CHECK: begin
                st_n = (crc_load == crc_ver) ? ST_DONE : ST_ERROR;
            end
            default: st_n = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so each one is
    // valid for the whole cycle the corresponding state occupies.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state      <= ST_IDLE;
            sreg       <= '0;
            cnt        <= '0;
            acc        <= '0;
            vcnt       <= '0;
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
            isol_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state      <= st_n;
            sreg       <= sreg_n;
            cnt        <= cnt_n;
            acc        <= acc_n;
            vcnt       <= vcnt_n;
            shift_en_q <= ((st_n == ST_LOAD) && (cnt_n != '0)) || (st_n == ST_VERIFY);
            head_q     <= ((st_n == ST_LOAD) && (cnt_n != '0)) ? sreg_n[DATA_W-1] : 1'b0;
            isol_q     <= (st_n == ST_DONE);
            busy_q     <= (st_n == ST_LOAD) || (st_n == ST_VERIFY) || (st_n == ST_CHECK);
            done_q     <= (st_n == ST_DONE);
            error_q    <= (st_n == ST_ERROR);
        end
    end

    ccff_crc8 u_crc_load (
        .clk    (prog_clk),
        .rst    (prog_reset),
        .clr    (crc_clr),
        .en     (load_shift),
        .bit_in (head_q),
        .crc    (crc_load)
    );

    ccff_crc8 u_crc_ver (
        .clk    (prog_clk),
        .rst    (prog_reset),
        .clr    (crc_clr),
        .en     (state == ST_VERIFY),
        .bit_in (ccff_tail),
        .crc    (crc_ver)
    );

    // Recirculation: the tail feeds straight back into the head.
    assign ccff_head     = (state == ST_VERIFY) ? ccff_tail : head_q;
    assign ccff_shift_en = shift_en_q;
    assign cfg.s_ready   = ready;
    assign IO_ISOL_N     = isol_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_ccff_cfg_loader.sv
// tb/tb_ccff_cfg_loader.sv - self-checking bench for ccff_cfg_loader with a 20/19-flop chain model
module tb_ccff_cfg_loader;

    localparam int CL = 20;
    localparam int DW = 8;

    logic prog_clk = 1'b0;
    logic prog_reset = 1'b1;
    logic start = 1'b0;
    logic ccff_head, ccff_tail, ccff_shift_en, io_isol_n, busy, done, error;

    ccff_cfg_loader_if #(.DATA_W(DW)) cfg_bus ();

    ccff_cfg_loader #(.CHAIN_LEN(CL), .DATA_W(DW)) dut (
        .prog_clk      (prog_clk),
        .prog_reset    (prog_reset),
        .start         (start),
        .cfg           (cfg_bus),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .ccff_shift_en (ccff_shift_en),
        .IO_ISOL_N     (io_isol_n),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 prog_clk = ~prog_clk;

    int cyc = 0;
    always @(posedge prog_clk) cyc <= cyc + 1;

    // Chain model: shift toward bit 19; tail taken at the configured length.
    logic [19:0] chain = '0;
    logic [4:0]  tail_idx = 5'd19;
    always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[18:0], ccff_head};
    always_comb ccff_tail = chain[tail_idx];

    logic [7:0] words [3];
    int  total = 0;
    int  bad = 0;
    bit  exp_q[$];
    int  mon_left = 0;
    int  zero_cnt = 0;
    bit  mon_started = 0;
    bit  abort_feed = 0;

    // Scoreboard consumer: every load shift pops one expected head bit.
    always @(negedge prog_clk) begin : mon
        bit e;
        if (mon_left > 0) begin
            if (ccff_shift_en) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL load_bit: shift with empty scoreboard at cyc %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (ccff_head !== e) begin
                        bad++;
                        $display("FAIL load_bit: cyc %0d head=%b required=%b", cyc, ccff_head, e);
                    end
                end
                mon_left--;
                mon_started = 1;
            end else if (mon_started) begin
                zero_cnt++;
            end
        end
    end

    task automatic arm_load();
        int pushed;
        exp_q.delete();
        pushed = 0;
        for (int w = 0; w < 3; w++)
            for (int b = DW - 1; b >= 0; b--)
                if (pushed < CL) begin
                    exp_q.push_back(words[w][b]);
                    pushed++;
                end
        mon_left = CL;
        zero_cnt = 0;
        mon_started = 0;
    endtask

    task automatic pulse_start(output int t);
        @(negedge prog_clk);
        start = 1'b1;
        t = cyc;
        @(negedge prog_clk);
        start = 1'b0;
    endtask

    task automatic feed(input bit stall);
        int n;
        for (int i = 0; i < 3; i++) begin
            cfg_bus.s_data = words[i];
            cfg_bus.s_valid = 1'b1;
            if (stall && i == 2) begin
                cfg_bus.s_valid = 1'b0;
                n = 0;
                while (!cfg_bus.s_ready && !abort_feed && n < 200) begin
                    @(negedge prog_clk);
                    n++;
                end
                repeat (5) @(negedge prog_clk);
                cfg_bus.s_valid = 1'b1;
            end
            n = 0;
            while (!cfg_bus.s_ready && !abort_feed && n < 200) begin
                @(negedge prog_clk);
                n++;
            end
            if (abort_feed || n >= 200) begin
                cfg_bus.s_valid = 1'b0;
                return;
            end
            @(posedge prog_clk);
            @(negedge prog_clk);
        end
        cfg_bus.s_valid = 1'b0;
    endtask

    task automatic wait_end(output int te);
        int n;
        n = 0;
        te = -1;
        while (n < 300) begin
            if (done || error) begin
                te = cyc;
                break;
            end
            @(negedge prog_clk);
            n++;
        end
    endtask

    task automatic run_load(input bit stall, input int len, output int t, output int te);
        tail_idx = 5'(len - 1);
        arm_load();
        pulse_start(t);
        feed(stall);
        wait_end(te);
    endtask

    task automatic test_reset();
        prog_reset = 1'b1;
        repeat (3) @(negedge prog_clk);
        total += 7;
        if (cfg_bus.s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready: got %b required 0", cfg_bus.s_ready); end
        if (ccff_shift_en !== 1'b0) begin bad++; $display("FAIL rst_shift_en: got %b required 0", ccff_shift_en); end
        if (ccff_head !== 1'b0) begin bad++; $display("FAIL rst_head: got %b required 0", ccff_head); end
        if (io_isol_n !== 1'b0) begin bad++; $display("FAIL rst_isol: got %b required 0", io_isol_n); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", busy); end
        if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b required 0", done); end
        if (error !== 1'b0) begin bad++; $display("FAIL rst_error: got %b required 0", error); end
        prog_reset = 1'b0;
        @(negedge prog_clk);
    endtask

    task automatic test_basic_load();
        int t, te;
        run_load(0, 20, t, te);
        total += 8;
        if (te !== t + 43) begin bad++; $display("FAIL basic_done_time: got %0d required %0d", te - t, 43); end
        if (done !== 1'b1) begin bad++; $display("FAIL basic_done: got %b required 1", done); end
        if (error !== 1'b0) begin bad++; $display("FAIL basic_error: got %b required 0", error); end
        if (io_isol_n !== 1'b1) begin bad++; $display("FAIL basic_isol: got %b required 1", io_isol_n); end
        if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy: got %b required 0", busy); end
        if (chain !== 20'hA53CF) begin bad++; $display("FAIL basic_chain: got %h required a53cf", chain); end
        if (zero_cnt !== 0) begin bad++; $display("FAIL basic_gaps: got %0d required 0", zero_cnt); end
        if (cfg_bus.s_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_done: got %b required 0", cfg_bus.s_ready); end
    endtask

    task automatic test_stall();
        int t, te;
        run_load(1, 20, t, te);
        total += 4;
        if (te !== t + 48) begin bad++; $display("FAIL stall_done_time: got %0d required %0d", te - t, 48); end
        if (zero_cnt !== 5) begin bad++; $display("FAIL stall_gaps: got %0d required 5", zero_cnt); end
        if (chain !== 20'hA53CF) begin bad++; $display("FAIL stall_chain: got %h required a53cf", chain); end
        if (io_isol_n !== 1'b1) begin bad++; $display("FAIL stall_isol: got %b required 1", io_isol_n); end
    endtask

    task automatic test_short_chain();
        int t, te;
        run_load(0, 19, t, te);
        total += 4;
        if (te !== t + 43) begin bad++; $display("FAIL short_end_time: got %0d required %0d", te - t, 43); end
        if (error !== 1'b1) begin bad++; $display("FAIL short_error: got %b required 1", error); end
        if (done !== 1'b0) begin bad++; $display("FAIL short_done: got %b required 0", done); end
        if (io_isol_n !== 1'b0) begin bad++; $display("FAIL short_isol: got %b required 0", io_isol_n); end
        tail_idx = 5'd19;
    endtask

    task automatic test_reset_mid();
        int t, te;
        tail_idx = 5'd19;
        arm_load();
        pulse_start(t);
        fork
            feed(0);
            begin
                while (cyc != t + 10) @(negedge prog_clk);
                prog_reset = 1'b1;
                abort_feed = 1'b1;
                @(negedge prog_clk);
                total += 5;
                if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b required 0", busy); end
                if (ccff_shift_en !== 1'b0) begin bad++; $display("FAIL mid_shift_en: got %b required 0", ccff_shift_en); end
                if (io_isol_n !== 1'b0) begin bad++; $display("FAIL mid_isol: got %b required 0", io_isol_n); end
                if (done !== 1'b0) begin bad++; $display("FAIL mid_done: got %b required 0", done); end
                if (cfg_bus.s_ready !== 1'b0) begin bad++; $display("FAIL mid_ready: got %b required 0", cfg_bus.s_ready); end
                prog_reset = 1'b0;
            end
        join
        abort_feed = 1'b0;
        exp_q.delete();
        mon_left = 0;
        run_load(0, 20, t, te);
        total += 3;
        if (te !== t + 43) begin bad++; $display("FAIL mid_reload_time: got %0d required %0d", te - t, 43); end
        if (done !== 1'b1) begin bad++; $display("FAIL mid_reload_done: got %b required 1", done); end
        if (chain !== 20'hA53CF) begin bad++; $display("FAIL mid_reload_chain: got %h required a53cf", chain); end
    endtask

    task automatic test_start_in_load();
        int t, te;
        arm_load();
        pulse_start(t);
        fork
            feed(0);
            begin
                while (cyc != t + 5) @(negedge prog_clk);
                start = 1'b1;
                @(negedge prog_clk);
                start = 1'b0;
            end
        join
        wait_end(te);
        total += 3;
        if (te !== t + 43) begin bad++; $display("FAIL busy_start_time: got %0d required %0d", te - t, 43); end
        if (done !== 1'b1) begin bad++; $display("FAIL busy_start_done: got %b required 1", done); end
        if (chain !== 20'hA53CF) begin bad++; $display("FAIL busy_start_chain: got %h required a53cf", chain); end
    endtask

    task automatic test_start_in_done();
        int t, te;
        arm_load();
        pulse_start(t);
        total += 3;
        if (io_isol_n !== 1'b0) begin bad++; $display("FAIL restart_isol: got %b required 0", io_isol_n); end
        if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy: got %b required 1", busy); end
        if (done !== 1'b0) begin bad++; $display("FAIL restart_done: got %b required 0", done); end
        feed(0);
        wait_end(te);
        total += 2;
        if (te !== t + 43) begin bad++; $display("FAIL restart_time: got %0d required %0d", te - t, 43); end
        if (io_isol_n !== 1'b1) begin bad++; $display("FAIL restart_final_isol: got %b required 1", io_isol_n); end
    endtask

    initial begin
        words[0] = 8'hA5;
        words[1] = 8'h3C;
        words[2] = 8'hF0;
        cfg_bus.s_data = '0;
        cfg_bus.s_valid = 1'b0;
        test_reset();
        test_basic_load();
        test_stall();
        test_short_chain();
        test_reset_mid();
        test_start_in_load();
        test_start_in_done();
        repeat (2) @(negedge prog_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ccff_cfg_loader.md
# ccff_cfg_loader

Configuration controller for the IO tile configuration chain. It accepts a bitstream as words over a valid/ready stream and serializes it MSB-first onto `ccff_head`. It gates chain shifting through a clock-enable, then verifies chain integrity by recirculating the chain once and comparing CRC-8 signatures. It holds the tiles' IO isolation asserted until a verified load completes. It sits between the host configuration port and the `ccff_head`/`ccff_tail` ends of the IO tile chain; an external ICG uses `ccff_shift_en` to gate `prog_clk` into the chain.

## Interface
Parameters:
- `CHAIN_LEN`, default 88: total configuration flops in the chain, ≥2.
- `DATA_W`, default 8: input word width, ≥1.

Ports:
- `prog_clk`, in, 1: the single clock.
- `prog_reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a load. Sampled in IDLE, DONE and ERROR; ignored otherwise.
- `s_data`, in, DATA_W: bitstream word, MSB shifted first.
- `s_valid`, in, 1: word valid.
- `s_ready`, out, 1: word accepted when `s_valid && s_ready`.
- `ccff_head`, out, 1: chain input.
- `ccff_tail`, in, 1: chain output.
- `ccff_shift_en`, out, 1: chain captures `ccff_head` at the end of any cycle where this is 1.
- `IO_ISOL_N`, out, 1: 0 = IOs isolated.
- `busy`, out, 1: in LOAD, VERIFY or CHECK.
- `done`, out, 1: level; high in DONE.
- `error`, out, 1: level; high in ERROR.

## Operation
States: IDLE, LOAD, VERIFY, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + `start` → LOAD. On that transition:
  - bit counter cleared;
  - CRC cleared to 0x00;
  - shift register emptied;
  - `IO_ISOL_N` driven 0.
- LOAD behaviour:
  - Word shift register plus a remaining-bits count.
  - `s_ready` = 1 when the count is 0, or when the count is 1 and a shift occurs this cycle. This gives gapless back-to-back words.
  - `ccff_shift_en` = 1 only when the count is ≥1.
  - On each shift: `ccff_head` = shift-register MSB; the CRC is updated with that bit.
  - When the shift-register count is 0 and no word is presented, `ccff_shift_en` = 0 and the chain holds (stall).
- LOAD → VERIFY after exactly CHAIN_LEN shifts.
  - Bits beyond CHAIN_LEN in the final word are discarded: the low-order bits when CHAIN_LEN mod DATA_W ≠ 0.
  - `s_ready` = 0 once CHAIN_LEN bits have been accepted.
- VERIFY behaviour:
  - `ccff_head` = `ccff_tail`, combinationally (recirculation).
  - `ccff_shift_en` = 1 for exactly CHAIN_LEN cycles.
  - A second CRC accumulates `ccff_tail` each cycle.
  - After a full rotation the chain content is unchanged.
- VERIFY → CHECK: one cycle with no shift. The two CRCs are compared.
  - Equal → DONE: `IO_ISOL_N` = 1.
  - Unequal → ERROR: `IO_ISOL_N` stays 0.
- CRC-8: polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
- Counters are sized $clog2(CHAIN_LEN+1). No wrap occurs; the counter saturates at CHAIN_LEN and never exceeds it.
- `start` while busy is ignored.
- `start` in DONE restarts the load and re-isolates the IOs on the next cycle.
- `s_valid` is ignored outside LOAD.

## Timing
- Reset values: state IDLE, `s_ready` 0, `ccff_shift_en` 0, `ccff_head` 0, `IO_ISOL_N` 0, `busy` 0, `done` 0, `error` 0.
- Reset mid-operation: aborts the load, returns to IDLE next edge, and leaves the chain content undefined, with isolation held.
- All outputs are registered except two combinational paths:
  - `ccff_head` during VERIFY;
  - `s_ready`.
- Unstalled latency, with `start` sampled at edge T:
  - LOAD and first `s_ready` at T+1;
  - shifts at cycles T+2 … T+1+CHAIN_LEN;
  - VERIFY at T+2+CHAIN_LEN … T+1+2·CHAIN_LEN;
  - CHECK at T+2+2·CHAIN_LEN;
  - `done`/`IO_ISOL_N`=1 from T+3+2·CHAIN_LEN.
- Each stall cycle adds one cycle.

## Structure
- Shared package `fpga_cfg_pkg`: state enum `cfg_state_t`, `CFG_CRC_POLY` = 8'h07, `CFG_CRC_INIT` = 8'h00.
- One sub-module `ccff_crc8`: serial bit-in CRC with clear/enable, 8-bit state. It is instanced twice, once for load and once for verify.

## Test plan
- CHAIN_LEN=20, DATA_W=8, chain model = 20-flop shift register.
  - Stimulus: words 0xA5, 0x3C, 0xF0, `s_valid` always high.
  - Required: chain holds 1010_0101_0011_1100_1111 (first bit deepest).
  - Required: `done` at T+43; `IO_ISOL_N` = 1; the last 4 bits of 0xF0 are discarded.
- Same load with `s_valid` dropped for 5 cycles after the second word.
  - Required: `ccff_shift_en` = 0 for exactly those 5 cycles; chain content identical; `done` at T+48.
- Chain model with 19 flops, same load.
  - Required: CRC mismatch; `error` = 1 at T+43; `IO_ISOL_N` stays 0.
- `prog_reset` asserted at cycle T+10 of a load.
  - Required: next cycle shows IDLE, `busy` = 0, `ccff_shift_en` = 0, `IO_ISOL_N` = 0.
  - Required: a new `start` then completes normally.
- Pulse `start` at T+5 during LOAD.
  - Required: ignored, timing unchanged.
- Pulse `start` in DONE.
  - Required: `IO_ISOL_N` = 0 and `busy` = 1 on the next cycle.
